// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the
// staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_e;

  localparam int DEF_N_DOMAINS   = 3;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_ACK_TIMEOUT = 1024;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Saturating cycle counter with clear, enable
// and a terminal-count expired flag.
module reset_seq_timer #(
  parameter int W    = 4,
  parameter int TERM = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [W-1:0] TermC = W'(TERM);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired_o = (cnt_q == TermC);

  // Stops at the terminal value so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Releases N reset domains one at a time, waiting
// for each ready acknowledge, with timeout/error.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS   = DEF_N_DOMAINS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  localparam int IW = idx_w(N_DOMAINS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_reset,
  input  logic [N_DOMAINS-1:0] domain_ready,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 all_ready,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [IW-1:0]        err_index
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IW-1:0] LastIdx =
    IW'(N_DOMAINS - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [N_DOMAINS-1:0] drst_q, drst_d;
  logic                 all_q, all_d;
  logic                 busy_q, busy_d;
  logic                 terr_q, terr_d;
  logic [IW-1:0]        eidx_q, eidx_d;

  logic          hold_clr, hold_en, hold_exp;
  logic          tmo_clr, tmo_en, tmo_exp;
  logic          rdy_cur;
  logic          low_any;
  logic [IW-1:0] low_idx;

  assign rdy_cur  = domain_ready[idx_q];
  assign hold_clr = (state_q != HOLD) || req_reset;
  assign hold_en  = (state_q == HOLD);
  assign tmo_clr  = (state_q != WAIT) || rdy_cur;
  assign tmo_en   = (state_q == WAIT);

  reset_seq_timer #(
    .W    (HW),
    .TERM (HOLD_CYCLES - 1)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (hold_clr),
    .en_i      (hold_en),
    .expired_o (hold_exp)
  );

  reset_seq_timer #(
    .W    (TW),
    .TERM (ACK_TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_exp)
  );

  // Scan downward so the lowest dropped index wins.
  always_comb begin
    low_any = 1'b0;
    low_idx = '0;
    for (int j = N_DOMAINS - 1; j >= 0; j--) begin
      if (!domain_ready[j]) begin
        low_any = 1'b1;
        low_idx = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    terr_d  = terr_q;
    eidx_d  = eidx_q;
    if (req_reset) begin
      state_d = HOLD;
      idx_d   = '0;
      terr_d  = 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (hold_exp) begin
            state_d = WAIT;
            idx_d   = '0;
          end
        end
        WAIT: begin
          if (rdy_cur) begin
            if (idx_q == LastIdx) begin
              state_d = DONE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else if (tmo_exp) begin
            state_d = ERROR;
            terr_d  = 1'b1;
            eidx_d  = idx_q;
          end
        end
        DONE: begin
          if (low_any) begin
            state_d = ERROR;
            terr_d  = 1'b1;
            eidx_d  = low_idx;
          end
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = HOLD;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs follow the next state so they register with it.
  always_comb begin
    drst_d = '1;
    all_d  = 1'b0;
    busy_d = 1'b0;
    unique case (state_d)
      HOLD: begin
        busy_d = 1'b1;
      end
      WAIT: begin
        busy_d = 1'b1;
        for (int j = 0; j < N_DOMAINS; j++) begin
          drst_d[j] = (j > int'(idx_d));
        end
      end
      DONE: begin
        drst_d = '0;
        all_d  = 1'b1;
      end
      default: begin
        drst_d = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      idx_q   <= '0;
      drst_q  <= '1;
      all_q   <= 1'b0;
      busy_q  <= 1'b1;
      terr_q  <= 1'b0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drst_q  <= drst_d;
      all_q   <= all_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      eidx_q  <= eidx_d;
    end
  end

  assign domain_rst  = drst_q;
  assign all_ready   = all_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign err_index   = eidx_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with
// N_DOMAINS=3, HOLD_CYCLES=16, ACK_TIMEOUT=64.
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       req_reset;
  logic [2:0] domain_ready;
  logic [2:0] domain_rst;
  logic       all_ready;
  logic       busy;
  logic       timeout_err;
  logic [1:0] err_index;

  int checks;
  int errors;

  reset_sequencer #(
    .N_DOMAINS   (3),
    .HOLD_CYCLES (16),
    .ACK_TIMEOUT (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_reset    (req_reset),
    .domain_ready (domain_ready),
    .domain_rst   (domain_rst),
    .all_ready    (all_ready),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .err_index    (err_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] rdy;
    logic [2:0] drst;
    logic       all;
    logic       bsy;
    logic       err;
    logic [1:0] eidx;
  } vec_t;

  vec_t tab[$];

  task automatic add(input int c, input logic [2:0] r,
                     input logic [2:0] d, input logic a,
                     input logic b, input logic e,
                     input logic [1:0] x);
    vec_t v;
    v.cyc = c; v.rdy = r; v.drst = d; v.all = a;
    v.bsy = b; v.err = e; v.eidx = x;
    tab.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h",
               nm, act, exp);
    end
  endtask

  task automatic reset_dut(input logic [2:0] r);
    rst          = 1'b1;
    req_reset    = 1'b0;
    domain_ready = r;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic run_table(input int sc, input int first,
                           input int last, input int ncyc);
    int k;
    k = first;
    for (int c = 0; c < ncyc; c++) begin
      while (k < last && tab[k+1].cyc <= c) k++;
      domain_ready = tab[k].rdy;
      chk($sformatf("s%0d c%0d drst", sc, c),
          32'(domain_rst), 32'(tab[k].drst));
      chk($sformatf("s%0d c%0d all", sc, c),
          32'(all_ready), 32'(tab[k].all));
      chk($sformatf("s%0d c%0d busy", sc, c),
          32'(busy), 32'(tab[k].bsy));
      chk($sformatf("s%0d c%0d terr", sc, c),
          32'(timeout_err), 32'(tab[k].err));
      chk($sformatf("s%0d c%0d eidx", sc, c),
          32'(err_index), 32'(tab[k].eidx));
      chk($sformatf("s%0d c%0d overlap", sc, c),
          32'(all_ready && (domain_rst != 3'b000)), 32'd0);
      step();
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    req_reset    = 1'b0;
    domain_ready = 3'b000;

    // s1: ready returned 2 cycles after each release
    add( 0, 3'b000, 3'b111, 0, 1, 0, 0);
    add(16, 3'b000, 3'b110, 0, 1, 0, 0);
    add(18, 3'b001, 3'b110, 0, 1, 0, 0);
    add(19, 3'b001, 3'b100, 0, 1, 0, 0);
    add(21, 3'b011, 3'b100, 0, 1, 0, 0);
    add(22, 3'b011, 3'b000, 0, 1, 0, 0);
    add(24, 3'b111, 3'b000, 0, 1, 0, 0);
    add(25, 3'b111, 3'b000, 1, 0, 0, 0);
    // s2: ready tied high
    add( 0, 3'b111, 3'b111, 0, 1, 0, 0);
    add(16, 3'b111, 3'b110, 0, 1, 0, 0);
    add(17, 3'b111, 3'b100, 0, 1, 0, 0);
    add(18, 3'b111, 3'b000, 0, 1, 0, 0);
    add(19, 3'b111, 3'b000, 1, 0, 0, 0);
    // s3: domain 1 never acknowledges
    add( 0, 3'b000, 3'b111, 0, 1, 0, 0);
    add(16, 3'b000, 3'b110, 0, 1, 0, 0);
    add(18, 3'b001, 3'b110, 0, 1, 0, 0);
    add(19, 3'b001, 3'b100, 0, 1, 0, 0);
    add(84, 3'b001, 3'b111, 0, 0, 1, 1);

    reset_dut(tab[0].rdy);
    run_table(1, 0, 7, 28);

    // s4: drop ready[2] for one cycle in DONE
    domain_ready = 3'b011;
    step();
    domain_ready = 3'b111;
    chk("s4 drst", 32'(domain_rst), 32'h7);
    chk("s4 all", 32'(all_ready), 32'h0);
    chk("s4 busy", 32'(busy), 32'h0);
    chk("s4 terr", 32'(timeout_err), 32'h1);
    chk("s4 eidx", 32'(err_index), 32'h2);
    repeat (3) step();
    chk("s4 hold drst", 32'(domain_rst), 32'h7);
    chk("s4 hold terr", 32'(timeout_err), 32'h1);
    req_reset = 1'b1;
    step();
    req_reset = 1'b0;
    chk("s4 req drst", 32'(domain_rst), 32'h7);
    chk("s4 req busy", 32'(busy), 32'h1);
    chk("s4 req terr", 32'(timeout_err), 32'h0);
    chk("s4 req all", 32'(all_ready), 32'h0);

    reset_dut(tab[8].rdy);
    run_table(2, 8, 12, 22);

    // s6: rst in DONE, also overriding req_reset
    chk("s6 pre all", 32'(all_ready), 32'h1);
    rst       = 1'b1;
    req_reset = 1'b1;
    step();
    req_reset = 1'b0;
    chk("s6 drst", 32'(domain_rst), 32'h7);
    chk("s6 all", 32'(all_ready), 32'h0);
    chk("s6 busy", 32'(busy), 32'h1);
    chk("s6 terr", 32'(timeout_err), 32'h0);
    chk("s6 eidx", 32'(err_index), 32'h0);
    repeat (2) step();
    chk("s6 held drst", 32'(domain_rst), 32'h7);
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("s6 c%0d drst", c),
          32'(domain_rst), 32'h7);
      step();
    end
    chk("s6 c16 drst", 32'(domain_rst), 32'h6);

    reset_dut(tab[13].rdy);
    run_table(3, 13, 17, 185);

    // s5: req_reset in WAIT(1) with ready[1] high
    reset_dut(3'b000);
    repeat (18) step();
    domain_ready = 3'b001;
    step();
    chk("s5 wait1 drst", 32'(domain_rst), 32'h4);
    step();
    domain_ready = 3'b011;
    req_reset    = 1'b1;
    step();
    req_reset    = 1'b0;
    domain_ready = 3'b000;
    chk("s5 busy", 32'(busy), 32'h1);
    chk("s5 all", 32'(all_ready), 32'h0);
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("s5 c%0d drst", c),
          32'(domain_rst), 32'h7);
      step();
    end
    chk("s5 c16 drst", 32'(domain_rst), 32'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter N_DOMAINS, default 3: number of downstream reset domains, range 1..8.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: cycles all domains stay in reset before the first release, minimum 2.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 1024: maximum cycles to wait for one domain's ready, minimum 2.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req_reset, input, 1: single-cycle soft restart request.
REQ-007 SHALL have port domain_ready, input, N_DOMAINS: per-domain "out of reset and operational" acknowledge.
REQ-008 SHALL have port domain_rst, output, N_DOMAINS: per-domain active-high reset.
REQ-009 SHALL have port all_ready, output, 1: high when every domain is released and acknowledged.
REQ-010 SHALL have port busy, output, 1: high while the sequence is in progress (HOLD, WAIT).
REQ-011 SHALL have port timeout_err, output, 1: sticky error flag.
REQ-012 SHALL have port err_index, output, $clog2(N_DOMAINS) (min 1): index of the failing domain.

Function
REQ-013 SHALL implement states HOLD, WAIT, DONE and ERROR; all outputs SHALL be registered.
REQ-014 In HOLD: domain_rst all ones, busy=1; a counter SHALL run so that the first cycle after rst low is cycle 0, domain_rst stays all ones through cycle HOLD_CYCLES-1, and domain_rst[0]=0 from cycle HOLD_CYCLES, in state WAIT with index 0.
REQ-015 In WAIT(i): domain_rst[j]=0 for j<=i, 1 for j>i; the timeout counter SHALL clear on entry.
REQ-016 domain_ready[i] sampled high in WAIT(i) with i<N_DOMAINS-1 SHALL clear domain_rst[i+1] on the next cycle (1-cycle latency); ready already high at release advances after exactly 1 cycle.
REQ-017 domain_ready[N_DOMAINS-1] sampled high SHALL enter DONE next cycle: all_ready=1, busy=0.
REQ-018 Only domain_ready[i] of the current index SHALL be evaluated in WAIT; other bits are ignored.
REQ-019 If ACK_TIMEOUT cycles elapse in WAIT(i) without ready, the next cycle SHALL enter ERROR: domain_rst all ones, timeout_err=1, err_index=i, busy=0.
REQ-020 In DONE, any domain_ready bit sampled low SHALL enter ERROR next cycle with err_index = lowest such index and domain_rst all ones.
REQ-021 ERROR SHALL persist until req_reset or rst.
REQ-022 req_reset in any state SHALL enter HOLD next cycle with the hold counter cleared, domain_rst all ones, all_ready=0 and timeout_err cleared; this has priority over simultaneous ready or timeout.
REQ-023 The timeout compare SHALL use a counter of $clog2(ACK_TIMEOUT+1) bits that never wraps.
REQ-024 all_ready SHALL never be high in the same cycle as any domain_rst bit.

Reset
REQ-025 rst high SHALL force state HOLD with the hold counter cleared, domain_rst all ones, all_ready=0, busy=1, timeout_err=0 and err_index=0 at the next edge, and SHALL override req_reset.
REQ-026 rst held high for multiple cycles SHALL hold that state; the HOLD count SHALL start on the first cycle rst is low.

Structure
REQ-027 A shared package reset_seq_pkg SHALL hold the state enum (HOLD, WAIT, DONE, ERROR) and the default parameter constants.
REQ-028 A single sub-module reset_seq_timer (clear, enable, terminal-count compare, expired flag) SHALL be instantiated twice: once for the hold count and once for the timeout count.

Verification
REQ-029 With N_DOMAINS=3, HOLD_CYCLES=16 and ACK_TIMEOUT=64, the bench SHALL cover: rst high 3 cycles then low, with ready returned 2 cycles after each release -> domain_rst=111 for cycles 0..15, 110 at 16, 100 at 19, 000 at 22, all_ready=1 at 25.
REQ-030 Bench SHALL cover: domain_ready tied high -> releases at cycles 16, 17 and 18, then all_ready=1 at 19.
REQ-031 Bench SHALL cover: domain_ready[1] never asserted -> ERROR at release of domain 1 + 64 + 1 cycles, domain_rst=111, timeout_err=1, err_index=1, and the state holds for 100 more cycles.
REQ-032 Bench SHALL cover: in DONE, drop domain_ready[2] for 1 cycle -> next cycle ERROR, err_index=2, all_ready=0.
REQ-033 Bench SHALL cover: req_reset pulse in WAIT(1) coinciding with domain_ready[1]=1 -> next cycle domain_rst=111 and HOLD, then a full sequence repeats with release of domain 0 16 cycles later.
REQ-034 Bench SHALL cover: rst asserted in DONE -> next edge domain_rst=111, all_ready=0, busy=1, timeout_err=0.
